conv3x3_pipe: RTL
=================

Name: conv3x3_pipe

Overview:
Pipelined 3x3 convolution stage. It sits directly downstream of the 3x3 window memory stage.
- Consumes nine 8-bit window pixels per cycle plus a valid qualifier.
- Applies a runtime-programmable signed 3x3 kernel, then a right shift, an optional absolute value and clamping to 0..255.
- Produces one 8-bit result pixel with a write strobe that feeds the result-memory write port (pixel + wr).
- Counts output pixels and flags the end of each 256x256 frame.

Parameters:
- PIX_W, 8, pixel width (unsigned).
- COEF_W, 8, kernel coefficient width (signed two's complement).
- FRAME_PIX, 65536, output pixels per frame (256x256).
- ABS_MODE, 0, 1 = take |sum| before clamping (edge kernels); 0 = negative results clamp to 0.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- soft_clr  in  1  synchronous clear of pipeline valids and pixel counter.
- in_valid  in  1  pix1..pix9 hold a valid window this cycle.
- pix1..pix9  in  8 each  window pixels, row-major (pix1 top-left, pix5 centre, pix9 bottom-right).
- k1..k9  in  COEF_W each  signed kernel coefficients, same ordering as the pixels.
- shift  in  3  arithmetic right shift applied to the sum (0..7).
- pixel_out  out  8  clamped result pixel.
- out_valid  out  1  pixel_out is valid; drives the downstream wr.
- pix_cnt  out  16  index of the next output pixel within the frame.
- frame_done  out  1  one-cycle pulse coincident with the last pixel of a frame.

Behaviour:
- Reset (rst_n=0, async): all pipeline registers, pixel_out, out_valid, pix_cnt and frame_done are 0.
- Stage 1 (multiply): each pixel is zero-extended to 9-bit signed and multiplied by its coefficient, giving nine 17-bit signed products. k1..k9 and shift are sampled here, so coefficient changes affect only windows entering after the change.
- Stage 2 (partial sums): three row sums of three products each, 19-bit signed.
- Stage 3 (final):
  - Sum the three row sums into a 21-bit signed total (no overflow possible).
  - Arithmetic right shift by the shift value captured in stage 1.
  - If ABS_MODE=1, take the absolute value.
  - Clamp: <0 gives 0, >255 gives 255, otherwise the low 8 bits. Register into pixel_out.
- Latency: exactly 3 cycles from in_valid to out_valid. Throughput: 1 window per cycle.
- Valid bit: travels with the data through v1, v2, v3; out_valid = v3.
- Bubbles: gaps in in_valid propagate as out_valid=0. pixel_out holds its last value during gaps and is don't-care.
- Counting: pix_cnt increments on each cycle with out_valid=1.
  - When out_valid=1 and pix_cnt==FRAME_PIX-1, frame_done=1 in that same cycle and pix_cnt wraps to 0 on the next edge.
  - frame_done is combinational from the registered out_valid and pix_cnt, so it is glitch-free relative to clk.
- soft_clr: synchronous; clears v1..v3, pix_cnt and frame_done on the next edge. Data in flight is discarded. If soft_clr and in_valid are asserted in the same cycle, soft_clr wins and that window is dropped.
- Reset mid-frame: pipeline and counter return to 0 immediately (async). The upstream stage must also be reset to restart the frame.
- No backpressure: the downstream write port always accepts.

Decomposition:
- Package conv_pkg holds:
  - PIX_W, COEF_W, PROD_W=17, ROW_W=19, SUM_W=21.
  - FRAME_PIX and CNT_W=16.
  - Kernel presets as constants: IDENTITY, BOX (all 1, shift 3), LAPLACE (centre 8, others -1), SOBEL_X.
- One sub-module, conv_sat_clip: combinational shift, optional absolute value and clamp from SUM_W to 8 bits. It is unit-testable on its own.

Test Plan:
- Identity kernel (k5=1, others 0, shift=0), pix5=0x7A with in_valid for 1 cycle -> pixel_out=0x7A with out_valid high exactly 3 cycles later, pix_cnt goes 0->1.
- Box kernel (all 1, shift=3), all pixels 200 -> 1800>>3=225 (0xE1). All pixels 255 with shift=0 -> 2295, clamped to 0xFF.
- Laplace kernel (centre 8, others -1), centre 10, neighbours 50 -> 80-400=-320. ABS_MODE=0 gives 0x00; ABS_MODE=1 gives 0xFF (320 clamped). Neighbours 9 -> 80-72=8 gives 0x08.
- Random in_valid pattern (~60% duty) over 100 windows -> out_valid pattern equals the in_valid pattern delayed 3 cycles. Results match a golden model bit-exactly.
- 65536 valid windows with gaps -> frame_done pulses once, on the 65536th out_valid. pix_cnt=0 afterwards, and the next frame counts from 0.
- Assert rst_n low mid-stream with 2 windows in flight -> out_valid=0, pix_cnt=0 immediately. No stale output after release. Repeat with soft_clr: same result one edge later.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared widths, frame constants and kernel presets for the 3x3 convolution
// stage.
//   PIX_W/COEF_W        : pixel width (unsigned) and coefficient width (signed)
//   PROD_W/ROW_W/SUM_W  : product, row-sum and total widths. They are sized so
//                         that no stage can overflow for 8-bit pixels and
//                         8-bit coefficients.
//   FRAME_PIX/CNT_W     : output pixels per 256x256 frame and counter width
//   KERN_*              : kernel presets. coef[0] is k1 (top-left) and
//                         coef[8] is k9 (bottom-right).
package conv_pkg;

    localparam int PIX_W     = 8;
    localparam int COEF_W    = 8;
    localparam int NTAP      = 9;
    localparam int PROD_W    = 17;
    localparam int ROW_W     = 19;
    localparam int SUM_W     = 21;
    localparam int SHIFT_W   = 3;
    localparam int FRAME_PIX = 65536;
    localparam int CNT_W     = 16;

    typedef logic [NTAP-1:0][COEF_W-1:0] kern_coefs_t;

    typedef struct packed {
        kern_coefs_t        coef;
        logic [SHIFT_W-1:0] shift;
    } kernel_t;

    // In the concatenations below the first element is k9 and the last is k1.
    localparam kernel_t KERN_IDENTITY = '{
        coef:  {8'sh00, 8'sh00, 8'sh00,
                8'sh00, 8'sh01, 8'sh00,
                8'sh00, 8'sh00, 8'sh00},
        shift: 3'd0
    };

    localparam kernel_t KERN_BOX = '{
        coef:  {8'sh01, 8'sh01, 8'sh01,
                8'sh01, 8'sh01, 8'sh01,
                8'sh01, 8'sh01, 8'sh01},
        shift: 3'd3
    };

    localparam kernel_t KERN_LAPLACE = '{
        coef:  {8'shFF, 8'shFF, 8'shFF,
                8'shFF, 8'sh08, 8'shFF,
                8'shFF, 8'shFF, 8'shFF},
        shift: 3'd0
    };

    // Horizontal gradient:
    //   [-1 0 1]
    //   [-2 0 2]
    //   [-1 0 1]
    localparam kernel_t KERN_SOBEL_X = '{
        coef:  {8'sh01, 8'sh00, 8'shFF,
                8'sh02, 8'sh00, 8'shFE,
                8'sh01, 8'sh00, 8'shFF},
        shift: 3'd0
    };

    // Saturate a signed total into the unsigned pixel range 0..255.
    function automatic logic [PIX_W-1:0] clamp_pix(input logic signed [SUM_W-1:0] v);
        logic [PIX_W-1:0] r;
        if (v < 0) begin
            r = '0;
        end else if (v > $signed(SUM_W'(255))) begin
            r = '1;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_sat_clip.sv
// Output conditioning for the convolution total. This block is purely
// combinational.
//   i_sum   : signed total (SUM_W bits)
//   i_shift : arithmetic right-shift amount, 0..7
//   o_pix   : result pixel after shift, optional |x| and clamp to 0..255
// When ABS_MODE is 1 the magnitude is taken before clamping, so strongly
// negative edge responses saturate high instead of going to zero.
module conv_sat_clip
    import conv_pkg::*;
#(
    parameter int ABS_MODE = 0
) (
    input  logic signed [SUM_W-1:0]   i_sum,
    input  logic        [SHIFT_W-1:0] i_shift,
    output logic        [PIX_W-1:0]   o_pix
);

    logic signed [SUM_W-1:0] w_shr;
    logic signed [SUM_W-1:0] w_mag;

    // The shift rounds toward minus infinity, so -1 >>> n stays at -1.
    assign w_shr = i_sum >>> i_shift;

    // Negating cannot overflow: |total| <= 9*255*128, which is far below 2^20.
    always_comb begin
        w_mag = w_shr;
        if ((ABS_MODE != 0) && w_shr[SUM_W-1]) begin
            w_mag = -w_shr;
        end
    end

    assign o_pix = clamp_pix(w_mag);

endmodule

// File: rtl/conv3x3_pipe.sv
// Three-stage pipelined 3x3 convolution sitting between the window memory
// and the result memory write port.
//   clk, rst_n        : clock and asynchronous active-low reset
//   soft_clr          : synchronous flush of the pipeline valids and the
//                       pixel counter
//   in_valid, pix1..9 : incoming window, row-major, pix5 is the centre
//   k1..k9, shift     : signed kernel and post-sum right shift. Both are
//                       sampled together with the window in stage 1.
//   pixel_out         : clamped result
//   out_valid         : write strobe for the downstream memory
//   pix_cnt           : index of the next output pixel in the frame
//   frame_done        : high together with the last pixel of a frame
// Pipeline: stage 1 forms the products, stage 2 forms the row sums, and
// stage 3 forms the total and conditions it. The result appears 3 cycles
// after the window is presented. There is no backpressure.
module conv3x3_pipe
    import conv_pkg::*;
#(
    parameter int PIX_W     = 8,
    parameter int COEF_W    = 8,
    parameter int FRAME_PIX = 65536,
    parameter int ABS_MODE  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     soft_clr,
    input  logic                     in_valid,
    input  logic        [PIX_W-1:0]  pix1,
    input  logic        [PIX_W-1:0]  pix2,
    input  logic        [PIX_W-1:0]  pix3,
    input  logic        [PIX_W-1:0]  pix4,
    input  logic        [PIX_W-1:0]  pix5,
    input  logic        [PIX_W-1:0]  pix6,
    input  logic        [PIX_W-1:0]  pix7,
    input  logic        [PIX_W-1:0]  pix8,
    input  logic        [PIX_W-1:0]  pix9,
    input  logic signed [COEF_W-1:0] k1,
    input  logic signed [COEF_W-1:0] k2,
    input  logic signed [COEF_W-1:0] k3,
    input  logic signed [COEF_W-1:0] k4,
    input  logic signed [COEF_W-1:0] k5,
    input  logic signed [COEF_W-1:0] k6,
    input  logic signed [COEF_W-1:0] k7,
    input  logic signed [COEF_W-1:0] k8,
    input  logic signed [COEF_W-1:0] k9,
    input  logic        [2:0]        shift,
    output logic        [PIX_W-1:0]  pixel_out,
    output logic                     out_valid,
    output logic        [CNT_W-1:0]  pix_cnt,
    output logic                     frame_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);

    logic        [PIX_W-1:0]   w_pix  [NTAP];
    logic signed [COEF_W-1:0]  w_coef [NTAP];
    logic signed [PROD_W-1:0]  w_prod [NTAP];
    logic signed [ROW_W-1:0]   w_row  [3];
    logic signed [SUM_W-1:0]   w_sum;
    logic        [PIX_W-1:0]   w_clip;
    logic                      w_last;

    logic signed [PROD_W-1:0]  r_prod [NTAP];
    logic        [SHIFT_W-1:0] r_shift1;
    logic                      r_v1;
    logic signed [ROW_W-1:0]   r_row  [3];
    logic        [SHIFT_W-1:0] r_shift2;
    logic                      r_v2;
    logic        [PIX_W-1:0]   r_pix_out;
    logic                      r_v3;
    logic        [CNT_W-1:0]   r_pix_cnt;

    assign w_pix[0] = pix1;
    assign w_pix[1] = pix2;
    assign w_pix[2] = pix3;
    assign w_pix[3] = pix4;
    assign w_pix[4] = pix5;
    assign w_pix[5] = pix6;
    assign w_pix[6] = pix7;
    assign w_pix[7] = pix8;
    assign w_pix[8] = pix9;

    assign w_coef[0] = k1;
    assign w_coef[1] = k2;
    assign w_coef[2] = k3;
    assign w_coef[3] = k4;
    assign w_coef[4] = k5;
    assign w_coef[5] = k6;
    assign w_coef[6] = k7;
    assign w_coef[7] = k8;
    assign w_coef[8] = k9;

    // Stage 1: multiply. The pixel is zero-extended and the coefficient is
    // sign-extended, both to the full product width, so the signed multiply
    // keeps exactly the bits that matter (|p| < 2^16).
    always_comb begin
        for (int i = 0; i < NTAP; i++) begin
            w_prod[i] = $signed({{(PROD_W-PIX_W){1'b0}}, w_pix[i]})
                      * $signed({{(PROD_W-COEF_W){w_coef[i][COEF_W-1]}}, w_coef[i]});
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NTAP; i++) begin
                r_prod[i] <= '0;
            end
            r_shift1 <= '0;
            r_v1     <= 1'b0;
        end else begin
            r_v1 <= in_valid && !soft_clr;
            if (in_valid) begin
                for (int i = 0; i < NTAP; i++) begin
                    r_prod[i] <= w_prod[i];
                end
                r_shift1 <= shift;
            end
        end
    end

    // Stage 2: row sums.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            w_row[r] = ROW_W'(r_prod[3*r])
                     + ROW_W'(r_prod[3*r+1])
                     + ROW_W'(r_prod[3*r+2]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                r_row[r] <= '0;
            end
            r_shift2 <= '0;
            r_v2     <= 1'b0;
        end else begin
            r_v2 <= r_v1 && !soft_clr;
            if (r_v1) begin
                for (int r = 0; r < 3; r++) begin
                    r_row[r] <= w_row[r];
                end
                r_shift2 <= r_shift1;
            end
        end
    end

    // Stage 3: total, shift, optional magnitude, clamp.
    assign w_sum = SUM_W'(r_row[0]) + SUM_W'(r_row[1]) + SUM_W'(r_row[2]);

    conv_sat_clip #(
        .ABS_MODE (ABS_MODE)
    ) u_sat_clip (
        .i_sum   (w_sum),
        .i_shift (r_shift2),
        .o_pix   (w_clip)
    );

    // pixel_out only loads on valid data and holds its value through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_out <= '0;
            r_v3      <= 1'b0;
        end else begin
            r_v3 <= r_v2 && !soft_clr;
            if (r_v2) begin
                r_pix_out <= w_clip;
            end
        end
    end

    // Output pixel counter. frame_done is decoded from registered state only,
    // so it carries no glitch from the datapath.
    assign w_last = r_v3 && (r_pix_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_cnt <= '0;
        end else if (soft_clr) begin
            r_pix_cnt <= '0;
        end else if (r_v3) begin
            r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
        end
    end

    assign pixel_out  = r_pix_out;
    assign out_valid  = r_v3;
    assign pix_cnt    = r_pix_cnt;
    assign frame_done = w_last;

endmodule
